// File: rtl/ram_access_pkg.sv
// ram_access_pkg: shared sizing constants and the response entry type
package ram_access_pkg;
  localparam int RESP_DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int DEF_DATASIZE = 18;
  typedef struct packed {
    logic write;
    logic [DEF_DATASIZE-1:0] data;
  } resp_entry_t;
endpackage

// File: rtl/ram_resp_fifo.sv
// ram_resp_fifo: 4-entry first-word-fall-through response buffer with occupancy count
module ram_resp_fifo
  import ram_access_pkg::*;
#(
  parameter type entry_t = resp_entry_t
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output entry_t           dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(RESP_DEPTH);
  entry_t mem [RESP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic pop_e;
  assign valid = count != '0;
  assign pop_e = pop & valid;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop_e);
      count <= count + CNT_W'(push) - CNT_W'(pop_e);
    end
  // The upstream credit limit makes a push into a full buffer impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && count == CNT_W'(RESP_DEPTH)));
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: credit-based request/response initiator for a synchronous single-port RAM.
// Write acknowledgements are produced only when RAM_ACCESS_CTRL_WACK_EN is defined.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int DATASIZE = 18,
  parameter int ADDRSIZE = 8,
  parameter int PIPELINED = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDRSIZE-1:0] req_addr,
  input  logic [DATASIZE-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATASIZE-1:0] resp_rdata,
  output logic                resp_write,
  output logic                ram_wen,
  output logic                ram_ren,
  output logic [ADDRSIZE-1:0] ram_addr,
  output logic [DATASIZE-1:0] ram_wdata,
  input  logic [DATASIZE-1:0] ram_rdata,
  output logic [CNT_W-1:0]    inflight
);
  localparam int LAT = 1 + PIPELINED;
`ifdef RAM_ACCESS_CTRL_WACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif
  typedef struct packed {
    logic write;
    logic [DATASIZE-1:0] data;
  } entry_t;
  logic [LAT-1:0] tok_v, tok_w;
  logic [CNT_W-1:0] fifo_count;
  logic accept, issue, tok_exit;
  entry_t push_data, pop_data;
  // Credits come from registered counts only, so a pop frees a slot one cycle later.
  assign req_ready = ~rst & ((inflight + fifo_count) < CNT_W'(RESP_DEPTH));
  assign accept = req_valid & req_ready;
  assign ram_wen = accept & req_write;
  assign ram_ren = accept & ~req_write;
  assign ram_addr = req_addr;
  assign ram_wdata = req_wdata;
  assign issue = ram_ren | (ram_wen & WACK);
  assign tok_exit = tok_v[LAT-1];
  assign push_data = '{write: tok_w[LAT-1], data: tok_w[LAT-1] ? '0 : ram_rdata};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tok_v <= '0;
      tok_w <= '0;
      inflight <= '0;
    end else begin
      tok_v <= LAT'({tok_v, issue});
      tok_w <= LAT'({tok_w, req_write & WACK});
      inflight <= inflight + CNT_W'(issue) - CNT_W'(tok_exit);
    end
  ram_resp_fifo #(.entry_t(entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(tok_exit),
    .din(push_data),
    .pop(resp_ready),
    .dout(pop_data),
    .valid(resp_valid),
    .count(fifo_count)
  );
  assign resp_rdata = resp_valid ? pop_data.data : '0;
  assign resp_write = resp_valid & pop_data.write;
endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATASIZE, 18, RAM data word width.
- ADDRSIZE, 8, RAM address width.
- PIPELINED, 0, set to 1 when the attached RAM has an extra output register (read latency 2 instead of 1).

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDRSIZE  request address.
- req_wdata  in  DATASIZE  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when high together with resp_valid.
- resp_rdata  out  DATASIZE  read data (0 for write acks).
- resp_write  out  1  1 = response is a write ack.
- ram_wen  out  1  RAM write enable.
- ram_ren  out  1  RAM read enable.
- ram_addr  out  ADDRSIZE  RAM address.
- ram_wdata  out  DATASIZE  RAM write data.
- ram_rdata  in  DATASIZE  RAM read data.
- inflight  out  3  count of issued responses not yet in the response FIFO.

Function
REQ-003 The block SHALL be the initiator for one read/write port of a synchronous single-clock RAM with read latency LAT = 1 + PIPELINED.
REQ-004 Acceptance: ram_wen = req_valid & req_ready & req_write; ram_ren = req_valid & req_ready & ~req_write. Both are combinational. ram_addr and ram_wdata pass through from req_addr and req_wdata.
REQ-005 Credit rule: req_ready = (inflight + fifo_count) < 4. It SHALL use registered counts only, so a same-cycle pop does not release a credit until the next cycle.
REQ-006 Each accepted request that produces a response SHALL enter a LAT-deep token shift register carrying the write flag. At the edge where the token exits, ram_rdata (or 0 for a write) SHALL be pushed into the 4-entry response FIFO.
REQ-007 Latency: a read accepted at edge N SHALL give resp_valid high in cycle N+2 (PIPELINED=0) or N+3 (PIPELINED=1), with no earlier resp_valid.
REQ-008 Responses SHALL be returned strictly in acceptance order.
REQ-009 resp_valid SHALL stay high and resp_rdata and resp_write SHALL stay stable until resp_ready.
REQ-010 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged. Push when full cannot occur by REQ-005 and SHALL be flagged by an assertion.
REQ-011 inflight SHALL increment on issue, decrement on token exit, and hold on both at once. Its maximum is 4.
REQ-012 Back-to-back requests SHALL be accepted every cycle while credit remains (full throughput with resp_ready held high).

Reset
REQ-013 While rst is high: req_ready=0, resp_valid=0, resp_rdata=0, resp_write=0, ram_wen=0, ram_ren=0, inflight=0. FIFO and token register SHALL be empty.
REQ-014 Reset mid-operation SHALL discard all in-flight and buffered responses. RAM writes already issued are not undone.
REQ-015 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-016 Macro RAM_ACCESS_CTRL_WACK_EN:
- Defined: every accepted write SHALL produce a response with resp_write=1 and resp_rdata=0, and SHALL consume a credit.
- Undefined: writes SHALL produce no response and no credit; they are gated only by req_ready; resp_write SHALL be tied 0.

Structure
REQ-017 Shared package ram_access_pkg SHALL hold RESP_DEPTH=4, the count width constant (3), and the response entry typedef (write flag plus data).
REQ-018 The response buffer SHALL be a sub-module ram_resp_fifo (synchronous, 4 entries, first-word-fall-through, count output).

Verification
REQ-019 Reset, then a single read of addr 0x05 holding 0x2A5A3 with PIPELINED=0 -> ram_ren high in the accept cycle; resp_valid in cycle N+2 with resp_rdata=0x2A5A3.
REQ-020 Same read with PIPELINED=1 -> resp_valid in cycle N+3 with the same data.
REQ-021 resp_ready=0 and 6 back-to-back reads -> exactly 4 accepted; req_ready=0 thereafter. Then resp_ready=1 -> 4 responses in order; the remaining 2 are accepted starting the cycle after the first pop.
REQ-022 Write 0x3FFFF to addr 0xFF then read addr 0xFF -> read returns 0x3FFFF. With WACK_EN: write ack (resp_write=1, data 0) precedes the read data. Without: only the read response.
REQ-023 rst pulsed while 3 reads are in flight -> resp_valid=0 immediately; no stale response after release; inflight=0.
REQ-024 Random read/write mix (1000 requests, random resp_ready) -> in-order data matches a reference model; no FIFO overflow assertion fires.
